// File: rtl/bsg_manycore_pkg.sv
// Shared manycore definitions used by the tile store-credit controller.
package bsg_manycore_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FENCE_WAIT = 2'd1,
        FENCE_DONE = 2'd2
    } bsg_manycore_store_credit_state_e;

endpackage

// File: rtl/bsg_manycore_store_credit_ctrl_if.sv
// Core/network-side handshake bundle of the store-credit controller.
interface bsg_manycore_store_credit_ctrl_if #(
    parameter int max_out_p = 16
);
    localparam int cnt_width_lp = $clog2(max_out_p + 1);

    logic                    v_i;
    logic                    ready_o;
    logic                    v_o;
    logic                    ready_i;
    logic                    ret_v_i;
    logic                    fence_v_i;
    logic                    fence_done_o;
    logic [cnt_width_lp-1:0] out_count_o;
    logic                    credit_avail_o;
    logic                    err_underflow_o;

    // slave is the controller; master is the core/network environment driving it
    modport slave (
        input  v_i, ready_i, ret_v_i, fence_v_i,
        output ready_o, v_o, fence_done_o, out_count_o, credit_avail_o, err_underflow_o
    );

    modport master (
        output v_i, ready_i, ret_v_i, fence_v_i,
        input  ready_o, v_o, fence_done_o, out_count_o, credit_avail_o, err_underflow_o
    );

endinterface

// File: rtl/bsg_counter_up_down_sat.sv
// Saturating up/down counter; simultaneous up and down cancel, and a down
// with nothing counted raises underflow_o instead of wrapping.
module bsg_counter_up_down_sat #(
    parameter int max_val_p = 16,
    localparam int width_lp = $clog2(max_val_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                up_i,
    input  logic                down_i,
    output logic [width_lp-1:0] count_o,
    output logic [width_lp-1:0] count_next_o,
    output logic                underflow_o
);

    localparam logic [width_lp-1:0] max_lp = width_lp'(max_val_p);

    logic [width_lp-1:0] count_r;

    function automatic logic [width_lp-1:0] sat_step(
        input logic [width_lp-1:0] cur,
        input logic                up,
        input logic                down
    );
        if (up && !down)
            return (cur == max_lp) ? cur : cur + width_lp'(1);
        else if (down && !up)
            return (cur == '0) ? cur : cur - width_lp'(1);
        else
            return cur;
    endfunction

    assign count_next_o = sat_step(count_r, up_i, down_i);
    assign underflow_o  = down_i & ~up_i & (count_r == '0);
    assign count_o      = count_r;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            count_r <= '0;
        else
            count_r <= count_next_o;
    end

endmodule

// File: rtl/bsg_manycore_store_credit_ctrl.sv
// Gates remote-store injection on an outstanding-store credit count and
// sequences memory fences until every outstanding store has returned.
module bsg_manycore_store_credit_ctrl
    import bsg_manycore_pkg::*;
#(
    parameter int max_out_p = 16
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    bsg_manycore_store_credit_ctrl_if.slave io
);

    localparam int cnt_width_lp = $clog2(max_out_p + 1);
    localparam logic [cnt_width_lp-1:0] max_lp = cnt_width_lp'(max_out_p);

    bsg_manycore_store_credit_state_e state_r, state_n;
    logic [cnt_width_lp-1:0]          count_r, count_n;
    logic                             can_issue, issue, underflow, err_r;

    // Registered-state only: a same-cycle return never frees a credit early.
    assign can_issue = (state_r == IDLE) && (count_r < max_lp);
    assign issue     = io.v_i & io.ready_i & can_issue & ~reset_i;

    assign io.v_o             = io.v_i & can_issue & ~reset_i;
    assign io.ready_o         = io.ready_i & can_issue & ~reset_i;
    assign io.credit_avail_o  = can_issue;
    assign io.out_count_o     = count_r;
    assign io.fence_done_o    = (state_r == FENCE_DONE);
    assign io.err_underflow_o = err_r;

    bsg_counter_up_down_sat #(
        .max_val_p(max_out_p)
    ) out_cnt (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .up_i        (issue),
        .down_i      (io.ret_v_i),
        .count_o     (count_r),
        .count_next_o(count_n),
        .underflow_o (underflow)
    );

    // Fence completion looks at the post-update count so the last return
    // and the move to FENCE_DONE land in the same cycle.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE:       if (io.fence_v_i) state_n = FENCE_WAIT;
            FENCE_WAIT: if (count_n == '0) state_n = FENCE_DONE;
            FENCE_DONE: state_n = IDLE;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= IDLE;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            err_r   <= err_r | underflow;
        end
    end

endmodule

// File: tb/tb_bsg_manycore_store_credit_ctrl.sv
// Directed bench for the store-credit controller with max_out_p = 16.
module tb_bsg_manycore_store_credit_ctrl;

    logic clk = 1'b0;
    logic reset_i;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    bsg_manycore_store_credit_ctrl_if #(.max_out_p(16)) bus ();

    bsg_manycore_store_credit_ctrl #(.max_out_p(16)) dut (
        .clk_i  (clk),
        .reset_i(reset_i),
        .io     (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rdy, input logic ret, input logic fence);
        bus.v_i       = v;
        bus.ready_i   = rdy;
        bus.ret_v_i   = ret;
        bus.fence_v_i = fence;
    endtask

    initial begin
        int issued;
        reset_i = 1'b1;
        drive(1, 1, 0, 0);
        tick();
        tick();
        #1;
        check("rst_ready_o", bus.ready_o, 0);
        check("rst_v_o", bus.v_o, 0);
        check("rst_count", bus.out_count_o, 0);
        check("rst_err", bus.err_underflow_o, 0);
        check("rst_fence_done", bus.fence_done_o, 0);

        // 20 cycles of offered stores, no returns: only 16 may go out
        reset_i = 1'b0;
        issued = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.v_o && bus.ready_o) issued++;
            tick();
        end
        #1;
        check("fill_issued", issued, 16);
        check("fill_count", bus.out_count_o, 16);
        check("fill_ready_o", bus.ready_o, 0);
        check("fill_v_o", bus.v_o, 0);
        check("fill_credit", bus.credit_avail_o, 0);

        // one return at full: no same-cycle bypass, credit next cycle
        bus.ret_v_i = 1'b1;
        #1;
        check("ret_no_bypass", bus.ready_o, 0);
        tick();
        bus.ret_v_i = 1'b0;
        #1;
        check("ret_count15", bus.out_count_o, 15);
        check("ret_ready_o", bus.ready_o, 1);
        bus.v_i = 1'b0;

        // drain to 3, then issue and return together for 5 cycles
        bus.ret_v_i = 1'b1;
        repeat (12) tick();
        bus.ret_v_i = 1'b0;
        #1;
        check("drain_count3", bus.out_count_o, 3);
        drive(1, 1, 1, 0);
        repeat (5) tick();
        drive(0, 0, 0, 0);
        #1;
        check("cancel_count3", bus.out_count_o, 3);
        check("cancel_err", bus.err_underflow_o, 0);

        // drain to 0, then one return too many
        bus.ret_v_i = 1'b1;
        repeat (3) tick();
        #1;
        check("drain_count0", bus.out_count_o, 0);
        check("drain_err0", bus.err_underflow_o, 0);
        tick();
        bus.ret_v_i = 1'b0;
        #1;
        check("uflow_count", bus.out_count_o, 0);
        check("uflow_err", bus.err_underflow_o, 1);
        repeat (3) tick();
        check("uflow_sticky", bus.err_underflow_o, 1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        #1;
        check("uflow_cleared", bus.err_underflow_o, 0);

        // issue and return together at count 0
        drive(1, 1, 1, 0);
        tick();
        drive(0, 0, 0, 0);
        #1;
        check("zero_cancel_count", bus.out_count_o, 0);
        check("zero_cancel_err", bus.err_underflow_o, 0);

        // fence with simultaneous issue from count 1; returns at +3 and +6
        drive(1, 1, 0, 0);
        tick();
        bus.fence_v_i = 1'b1;
        #1;
        check("fence_issue_ready", bus.ready_o, 1);
        tick();
        bus.fence_v_i = 1'b0;
        #1;
        check("fence_count2", bus.out_count_o, 2);
        check("fence_credit", bus.credit_avail_o, 0);
        for (int c = 1; c <= 8; c++) begin
            bus.ret_v_i = (c == 3) || (c == 6);
            #1;
            check($sformatf("fence_done_c%0d", c), bus.fence_done_o, (c == 7) ? 1 : 0);
            check($sformatf("fence_ready_c%0d", c), bus.ready_o, (c == 8) ? 1 : 0);
            check($sformatf("fence_v_o_c%0d", c), bus.v_o, (c == 8) ? 1 : 0);
            tick();
        end
        drive(0, 0, 0, 0);
        #1;
        check("fence_resume_count", bus.out_count_o, 1);

        // fence at count 0: done pulse two cycles after the request
        bus.ret_v_i = 1'b1;
        tick();
        bus.ret_v_i = 1'b0;
        #1;
        check("f0_count", bus.out_count_o, 0);
        bus.fence_v_i = 1'b1;
        tick();
        bus.fence_v_i = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            #1;
            check($sformatf("f0_done_c%0d", c), bus.fence_done_o, (c == 2) ? 1 : 0);
            tick();
        end
        check("f0_idle_credit", bus.credit_avail_o, 1);

        // reset while waiting on a fence with 4 outstanding
        drive(1, 1, 0, 0);
        repeat (4) tick();
        bus.v_i = 1'b0;
        #1;
        check("rf_count4", bus.out_count_o, 4);
        bus.fence_v_i = 1'b1;
        tick();
        bus.fence_v_i = 1'b0;
        #1;
        check("rf_wait_credit", bus.credit_avail_o, 0);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        #1;
        check("rf_count0", bus.out_count_o, 0);
        check("rf_idle_credit", bus.credit_avail_o, 1);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("rf_no_done_c%0d", c), bus.fence_done_o, 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
